// File: rtl/ds_es_register.sv
// ds_es_register: decode-to-execute pipeline register with single-bubble load-use stall, flush and hold
module ds_es_register #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 5,
   parameter int CWIDTH = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              ds_i_valid,
   input  logic [AWIDTH-1:0] ds_i_addr_rs1,
   input  logic [AWIDTH-1:0] ds_i_addr_rs2,
   input  logic [AWIDTH-1:0] ds_i_addr_rd,
   input  logic              ds_i_use_rs1,
   input  logic              ds_i_use_rs2,
   input  logic [DWIDTH-1:0] ds_i_data_rs1,
   input  logic [DWIDTH-1:0] ds_i_data_rs2,
   input  logic [DWIDTH-1:0] ds_i_imm,
   input  logic [DWIDTH-1:0] ds_i_pc,
   input  logic [3:0]        ds_i_alu_op,
   input  logic              ds_i_regwrite,
   input  logic              ds_i_memread,
   input  logic              ds_i_memwrite,
   input  logic              ds_i_memtoreg,
   input  logic              ds_i_alusrc,
   input  logic              i_flush,
   input  logic              i_hold,
   output logic              ds_es_o_valid,
   output logic [AWIDTH-1:0] ds_es_o_addr_rs1,
   output logic [AWIDTH-1:0] ds_es_o_addr_rs2,
   output logic [AWIDTH-1:0] ds_es_o_addr_rd,
   output logic [DWIDTH-1:0] ds_es_o_data_rs1,
   output logic [DWIDTH-1:0] ds_es_o_data_rs2,
   output logic [DWIDTH-1:0] ds_es_o_imm,
   output logic [DWIDTH-1:0] ds_es_o_pc,
   output logic [3:0]        ds_es_o_alu_op,
   output logic              ds_es_o_regwrite,
   output logic              ds_es_o_memread,
   output logic              ds_es_o_memwrite,
   output logic              ds_es_o_memtoreg,
   output logic              ds_es_o_alusrc,
   output logic              o_stall,
   output logic [CWIDTH-1:0] o_bubble_cnt
);
   typedef enum logic {RUN, BUBBLE} state_t;
   state_t state;
   logic haz, load, kill;
   assign haz = ds_es_o_valid & ds_es_o_memread & (ds_es_o_addr_rd != '0) & ds_i_valid &
                ((ds_i_use_rs1 & (ds_i_addr_rs1 == ds_es_o_addr_rd)) |
                 (ds_i_use_rs2 & (ds_i_addr_rs2 == ds_es_o_addr_rd)));
   assign o_stall = (state == RUN) & haz & ~i_flush & ~i_hold;
   // flush overrides hold; both flush and stall load a bubble
   assign load = i_flush | ~i_hold;
   assign kill = i_flush | o_stall;
   always_ff @(posedge i_clk or negedge i_rst)
      if (!i_rst) begin
         ds_es_o_valid    <= 1'b0;
         ds_es_o_addr_rs1 <= '0;
         ds_es_o_addr_rs2 <= '0;
         ds_es_o_addr_rd  <= '0;
         ds_es_o_data_rs1 <= '0;
         ds_es_o_data_rs2 <= '0;
         ds_es_o_imm      <= '0;
         ds_es_o_pc       <= '0;
         ds_es_o_alu_op   <= '0;
         ds_es_o_regwrite <= 1'b0;
         ds_es_o_memread  <= 1'b0;
         ds_es_o_memwrite <= 1'b0;
         ds_es_o_memtoreg <= 1'b0;
         ds_es_o_alusrc   <= 1'b0;
         o_bubble_cnt     <= '0;
         state            <= RUN;
      end else if (load) begin
         ds_es_o_valid    <= ~kill & ds_i_valid;
         ds_es_o_addr_rs1 <= kill ? '0 : ds_i_addr_rs1;
         ds_es_o_addr_rs2 <= kill ? '0 : ds_i_addr_rs2;
         ds_es_o_addr_rd  <= kill ? '0 : ds_i_addr_rd;
         ds_es_o_data_rs1 <= kill ? '0 : ds_i_data_rs1;
         ds_es_o_data_rs2 <= kill ? '0 : ds_i_data_rs2;
         ds_es_o_imm      <= kill ? '0 : ds_i_imm;
         ds_es_o_pc       <= kill ? '0 : ds_i_pc;
         ds_es_o_alu_op   <= kill ? '0 : ds_i_alu_op;
         // never advertise a write to r0 toward forwarding
         ds_es_o_regwrite <= ~kill & ds_i_regwrite & ds_i_valid & (ds_i_addr_rd != '0);
         ds_es_o_memread  <= ~kill & ds_i_memread & ds_i_valid;
         ds_es_o_memwrite <= ~kill & ds_i_memwrite & ds_i_valid;
         ds_es_o_memtoreg <= ~kill & ds_i_memtoreg;
         ds_es_o_alusrc   <= ~kill & ds_i_alusrc;
         state            <= o_stall ? BUBBLE : RUN;
         if (o_stall && !(&o_bubble_cnt)) o_bubble_cnt <= o_bubble_cnt + 1'b1;
      end
endmodule

// File: tb/tb_ds_es_register.sv
// tb_ds_es_register: table-driven directed check of ds_es_register with a 2-bit bubble counter
module tb_ds_es_register;
   localparam int DW = 32, AW = 5, CW = 2;
   logic i_clk = 1'b0, i_rst = 1'b0;
   logic ds_i_valid, ds_i_use_rs1, ds_i_use_rs2;
   logic [AW-1:0] ds_i_addr_rs1, ds_i_addr_rs2, ds_i_addr_rd;
   logic [DW-1:0] ds_i_data_rs1, ds_i_data_rs2, ds_i_imm, ds_i_pc;
   logic [3:0] ds_i_alu_op;
   logic ds_i_regwrite, ds_i_memread, ds_i_memwrite, ds_i_memtoreg, ds_i_alusrc;
   logic i_flush, i_hold;
   logic ds_es_o_valid;
   logic [AW-1:0] ds_es_o_addr_rs1, ds_es_o_addr_rs2, ds_es_o_addr_rd;
   logic [DW-1:0] ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm, ds_es_o_pc;
   logic [3:0] ds_es_o_alu_op;
   logic ds_es_o_regwrite, ds_es_o_memread, ds_es_o_memwrite, ds_es_o_memtoreg, ds_es_o_alusrc;
   logic o_stall;
   logic [CW-1:0] o_bubble_cnt;
   logic [154:0] full;
   int n_vec = 0, n_bad = 0;

   ds_es_register #(.DWIDTH(DW), .AWIDTH(AW), .CWIDTH(CW)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .ds_i_valid(ds_i_valid), .ds_i_addr_rs1(ds_i_addr_rs1), .ds_i_addr_rs2(ds_i_addr_rs2),
      .ds_i_addr_rd(ds_i_addr_rd), .ds_i_use_rs1(ds_i_use_rs1), .ds_i_use_rs2(ds_i_use_rs2),
      .ds_i_data_rs1(ds_i_data_rs1), .ds_i_data_rs2(ds_i_data_rs2), .ds_i_imm(ds_i_imm),
      .ds_i_pc(ds_i_pc), .ds_i_alu_op(ds_i_alu_op), .ds_i_regwrite(ds_i_regwrite),
      .ds_i_memread(ds_i_memread), .ds_i_memwrite(ds_i_memwrite), .ds_i_memtoreg(ds_i_memtoreg),
      .ds_i_alusrc(ds_i_alusrc), .i_flush(i_flush), .i_hold(i_hold),
      .ds_es_o_valid(ds_es_o_valid), .ds_es_o_addr_rs1(ds_es_o_addr_rs1),
      .ds_es_o_addr_rs2(ds_es_o_addr_rs2), .ds_es_o_addr_rd(ds_es_o_addr_rd),
      .ds_es_o_data_rs1(ds_es_o_data_rs1), .ds_es_o_data_rs2(ds_es_o_data_rs2),
      .ds_es_o_imm(ds_es_o_imm), .ds_es_o_pc(ds_es_o_pc), .ds_es_o_alu_op(ds_es_o_alu_op),
      .ds_es_o_regwrite(ds_es_o_regwrite), .ds_es_o_memread(ds_es_o_memread),
      .ds_es_o_memwrite(ds_es_o_memwrite), .ds_es_o_memtoreg(ds_es_o_memtoreg),
      .ds_es_o_alusrc(ds_es_o_alusrc), .o_stall(o_stall), .o_bubble_cnt(o_bubble_cnt)
   );

   always #5 i_clk = ~i_clk;

   assign full = {ds_es_o_valid, ds_es_o_addr_rs1, ds_es_o_addr_rs2, ds_es_o_addr_rd,
                  ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm, ds_es_o_pc, ds_es_o_alu_op,
                  ds_es_o_regwrite, ds_es_o_memread, ds_es_o_memwrite, ds_es_o_memtoreg,
                  ds_es_o_alusrc, o_bubble_cnt};

   typedef struct {
      logic v, u1, u2, rw, mr, fl, ho;
      logic [4:0] rs1, rs2, rd;
      logic [31:0] d;
      logic e_stall, e_valid, e_rw, e_mr;
      logic [4:0] e_rd;
      logic [31:0] e_d;
      logic [1:0] e_cnt;
   } vec_t;
   vec_t tbl [27];

   function automatic vec_t mk(int v, int rs1, int rs2, int rd, int u1, int u2, int rw, int mr,
                               int fl, int ho, logic [31:0] d, int st, int ev, int erd, int erw,
                               int emr, logic [31:0] ed, int ec);
      vec_t r;
      r.v = v[0]; r.rs1 = rs1[4:0]; r.rs2 = rs2[4:0]; r.rd = rd[4:0];
      r.u1 = u1[0]; r.u2 = u2[0]; r.rw = rw[0]; r.mr = mr[0]; r.fl = fl[0]; r.ho = ho[0];
      r.d = d; r.e_stall = st[0]; r.e_valid = ev[0]; r.e_rd = erd[4:0]; r.e_rw = erw[0];
      r.e_mr = emr[0]; r.e_d = ed; r.e_cnt = ec[1:0];
      return r;
   endfunction

   task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t t);
      ds_i_valid = t.v; ds_i_addr_rs1 = t.rs1; ds_i_addr_rs2 = t.rs2; ds_i_addr_rd = t.rd;
      ds_i_use_rs1 = t.u1; ds_i_use_rs2 = t.u2; ds_i_regwrite = t.rw; ds_i_memread = t.mr;
      ds_i_memwrite = 1'b0; ds_i_memtoreg = t.mr; ds_i_alusrc = t.u2;
      ds_i_data_rs1 = t.d; ds_i_data_rs2 = t.d ^ 32'hFFFF_0000; ds_i_imm = t.d + 32'd1;
      ds_i_pc = t.d << 2; ds_i_alu_op = t.d[3:0]; i_flush = t.fl; i_hold = t.ho;
   endtask

   initial begin
      //           v rs1 rs2 rd u1 u2 rw mr fl ho d        st ev rd rw mr e_d      cnt
      tbl[0]  = mk(1, 1,  2, 3, 1, 1, 1, 0, 0, 0, 32'h11, 0, 1, 3, 1, 0, 32'h11, 0);
      tbl[1]  = mk(1, 3,  0, 5, 1, 0, 1, 1, 0, 0, 32'h22, 0, 1, 5, 1, 1, 32'h22, 0);
      tbl[2]  = mk(1, 5,  6, 7, 1, 1, 1, 0, 0, 0, 32'h33, 1, 0, 0, 0, 0, 32'h0,  1);
      tbl[3]  = mk(1, 5,  6, 7, 1, 1, 1, 0, 0, 0, 32'h33, 0, 1, 7, 1, 0, 32'h33, 1);
      tbl[4]  = mk(1, 1,  0, 0, 1, 0, 1, 1, 0, 0, 32'h44, 0, 1, 0, 0, 1, 32'h44, 1);
      tbl[5]  = mk(1, 0,  0, 8, 1, 1, 1, 0, 0, 0, 32'h55, 0, 1, 8, 1, 0, 32'h55, 1);
      tbl[6]  = mk(1, 1,  0, 5, 1, 0, 1, 1, 0, 0, 32'h66, 0, 1, 5, 1, 1, 32'h66, 1);
      tbl[7]  = mk(1, 1,  5, 9, 1, 0, 1, 0, 0, 0, 32'h77, 0, 1, 9, 1, 0, 32'h77, 1);
      tbl[8]  = mk(1, 2,  0, 0, 1, 0, 1, 0, 0, 0, 32'h88, 0, 1, 0, 0, 0, 32'h88, 1);
      tbl[9]  = mk(0, 1,  5, 4, 1, 1, 1, 1, 0, 0, 32'h99, 0, 0, 4, 0, 0, 32'h99, 1);
      tbl[10] = mk(1, 1,  0, 5, 0, 0, 1, 1, 0, 0, 32'hAA, 0, 1, 5, 1, 1, 32'hAA, 1);
      tbl[11] = mk(1, 5,  0, 10,1, 0, 1, 0, 1, 0, 32'hBB, 0, 0, 0, 0, 0, 32'h0,  1);
      tbl[12] = mk(1, 1,  0, 6, 0, 0, 1, 1, 0, 0, 32'hCC, 0, 1, 6, 1, 1, 32'hCC, 1);
      for (int i = 13; i < 16; i++)
         tbl[i] = mk(1, 1, 6, 11, 0, 1, 1, 0, 0, 1, 32'hDD, 0, 1, 6, 1, 1, 32'hCC, 1);
      tbl[16] = mk(1, 1,  6, 11,0, 1, 1, 0, 0, 0, 32'hDD, 1, 0, 0, 0, 0, 32'h0,  2);
      tbl[17] = mk(1, 1,  6, 11,0, 1, 1, 0, 0, 0, 32'hDD, 0, 1, 11,1, 0, 32'hDD, 2);
      tbl[18] = mk(1, 1,  0, 12,0, 0, 1, 1, 0, 0, 32'hE0, 0, 1, 12,1, 1, 32'hE0, 2);
      tbl[19] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE1, 1, 0, 0, 0, 0, 32'h0,  3);
      tbl[20] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE1, 0, 1, 13,1, 0, 32'hE1, 3);
      tbl[21] = mk(1, 1,  0, 12,0, 0, 1, 1, 0, 0, 32'hE2, 0, 1, 12,1, 1, 32'hE2, 3);
      tbl[22] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE3, 1, 0, 0, 0, 0, 32'h0,  3);
      tbl[23] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE3, 0, 1, 13,1, 0, 32'hE3, 3);
      tbl[24] = mk(1, 1,  0, 12,0, 0, 1, 1, 0, 0, 32'hE4, 0, 1, 12,1, 1, 32'hE4, 3);
      tbl[25] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE5, 1, 0, 0, 0, 0, 32'h0,  3);
      tbl[26] = mk(1, 12, 0, 13,1, 0, 1, 0, 0, 0, 32'hE5, 0, 1, 13,1, 0, 32'hE5, 3);

      // reset with garbage on every input
      apply(mk(1, 31, 31, 31, 1, 1, 1, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0));
      ds_i_memwrite = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      check("reset outputs", full, 0);
      check("reset stall", o_stall, 0);
      @(negedge i_clk);
      i_rst = 1'b1;

      for (int i = 0; i < 27; i++) begin
         @(negedge i_clk);
         apply(tbl[i]);
         #1;
         check($sformatf("v%0d stall", i), o_stall, tbl[i].e_stall);
         @(posedge i_clk);
         #1;
         check($sformatf("v%0d es", i),
               {ds_es_o_valid, ds_es_o_addr_rd, ds_es_o_regwrite, ds_es_o_memread, ds_es_o_data_rs1, o_bubble_cnt},
               {tbl[i].e_valid, tbl[i].e_rd, tbl[i].e_rw, tbl[i].e_mr, tbl[i].e_d, tbl[i].e_cnt});
      end

      // reset asserted while the bubble sits in execute
      @(negedge i_clk);
      apply(mk(1, 1, 0, 5, 0, 0, 1, 1, 0, 0, 32'h100, 0, 0, 0, 0, 0, 0, 0));
      @(negedge i_clk);
      apply(mk(1, 5, 6, 7, 1, 1, 1, 0, 0, 0, 32'h200, 0, 0, 0, 0, 0, 0, 0));
      ds_i_data_rs1 = 32'h1234_5678; ds_i_data_rs2 = 32'h9ABC_DEF0; ds_i_imm = 32'hFFFF_FFF0;
      ds_i_pc = 32'h0040_0010; ds_i_alu_op = 4'hA; ds_i_memwrite = 1'b1; ds_i_memtoreg = 1'b0;
      ds_i_alusrc = 1'b1;
      #1;
      check("midbub stall", o_stall, 1);
      @(posedge i_clk);
      #1;
      check("midbub bubble", {ds_es_o_valid, o_stall}, 2'b00);
      #2;
      i_rst = 1'b0;
      #1;
      check("midbub reset", {full, o_stall}, 0);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("post reset stall", o_stall, 0);
      @(posedge i_clk);
      #1;
      check("full capture", full,
            {1'b1, 5'd5, 5'd6, 5'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFF0,
             32'h0040_0010, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/ds_es_register.md
# ds_es_register

Decode-to-execute pipeline register with load-use hazard detection for the MIPS pipeline. Captures decoded operands and control each cycle and presents them to the execute stage. Its registered rs1/rs2 addresses and the execute-stage destination/regwrite drive the forwarding unit. Inserts exactly one bubble per load-use hazard, honours branch flush and external memory hold, and guarantees regwrite is never asserted toward forwarding for register 0.

## Interface
- DWIDTH, 32, data/immediate/PC width
- AWIDTH, 5, register address width
- CWIDTH, 16, bubble counter width

- i_clk  in  1  rising-edge clock
- i_rst  in  1  asynchronous, active-low reset
- ds_i_valid  in  1  decode slot holds a real instruction
- ds_i_addr_rs1, ds_i_addr_rs2, ds_i_addr_rd  in  AWIDTH  source/destination addresses
- ds_i_use_rs1, ds_i_use_rs2  in  1  instruction actually reads rs1/rs2
- ds_i_data_rs1, ds_i_data_rs2, ds_i_imm, ds_i_pc  in  DWIDTH  operand values, immediate, PC
- ds_i_alu_op  in  4  ALU operation
- ds_i_regwrite, ds_i_memread, ds_i_memwrite, ds_i_memtoreg, ds_i_alusrc  in  1  control bits
- i_flush  in  1  branch taken in execute; kill decode slot
- i_hold  in  1  memory stall; freeze register
- ds_es_o_valid  out  1  execute slot valid
- ds_es_o_addr_rs1, ds_es_o_addr_rs2, ds_es_o_addr_rd  out  AWIDTH  registered addresses (to forwarding)
- ds_es_o_data_rs1, ds_es_o_data_rs2, ds_es_o_imm, ds_es_o_pc  out  DWIDTH  registered data
- ds_es_o_alu_op  out  4  registered ALU op
- ds_es_o_regwrite, ds_es_o_memread, ds_es_o_memwrite, ds_es_o_memtoreg, ds_es_o_alusrc  out  1  registered control
- o_stall  out  1  combinational; hold PC and IF/ID this cycle
- o_bubble_cnt  out  CWIDTH  count of load-use bubbles inserted

## Operation
- Hazard term: haz = ds_es_o_valid & ds_es_o_memread & (ds_es_o_addr_rd != 0) & ds_i_valid & ((ds_i_use_rs1 & ds_i_addr_rs1 == ds_es_o_addr_rd) | (ds_i_use_rs2 & ds_i_addr_rs2 == ds_es_o_addr_rd)).
- FSM states: RUN, BUBBLE. o_stall = (state == RUN) & haz & ~i_flush & ~i_hold.
- Per-edge update priority: i_flush > i_hold > o_stall > normal.
  - i_flush: load bubble, state -> RUN.
  - i_hold: all registers, state and counter unchanged.
  - o_stall: load bubble, state -> BUBBLE, o_bubble_cnt += 1 (saturating at all-ones).
  - normal: capture all ds_i_* fields, valid = ds_i_valid, state -> RUN.
- Bubble: valid, all control bits, alu_op, all addresses = 0; data, imm, pc = 0.
- Register-zero rule: captured regwrite = ds_i_regwrite & ds_i_valid & (ds_i_addr_rd != 0). memread/memwrite captured only when ds_i_valid.
- BUBBLE state suppresses hazard detection, so at most one bubble per load. Re-entry to BUBBLE requires a RUN cycle.

## Timing
- Reset (i_rst low, async): all outputs 0, state RUN, o_bubble_cnt 0. o_stall reads 0.
- Latency: decode inputs appear on ds_es_o_* one edge after capture.
- Load-use: cycle N has hazard and o_stall=1. Edge N+1 places a bubble in execute while decode holds. Cycle N+1 is in BUBBLE with o_stall=0. Edge N+2 captures the held instruction.
- Flush coincident with hazard: flush wins, no stall, counter unchanged.
- Hold coincident with hazard: o_stall=0, no state change. Hazard is re-evaluated when hold drops.
- Reset asserted mid-bubble returns immediately to RUN with outputs cleared.

## Test plan
- Reset: drive garbage inputs, i_rst=0 -> all outputs 0, o_bubble_cnt=0. Release, then a valid add with rd=3 -> next edge ds_es_o_valid=1, addr_rd=3, regwrite=1.
- Load-use: lw rd=5, then add rs1=5 (use_rs1=1) -> o_stall=1 one cycle, one bubble (valid=0), add appears two edges after lw, o_bubble_cnt=1.
- No false hazard: lw rd=0, then add rs1=0 -> o_stall=0. Also lw rd=5, then add rs2=5 with use_rs2=0 -> o_stall=0.
- r0 write: valid instruction rd=0, regwrite=1 -> ds_es_o_regwrite=0.
- Flush/hold: hazard with i_flush=1 -> bubble loaded, o_stall=0, count unchanged. i_hold=1 for 3 cycles -> outputs frozen, then resume.
- Counter saturation: CWIDTH=2, 5 load-use events -> o_bubble_cnt stays 3.
